// File: rtl/feeder_pkg.sv
// Shared types and instruction codes for the MAC-array west-edge feeder.
package feeder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        KLOAD,
        EXEC,
        DRAIN,
        DONE
    } state_t;

    localparam logic [1:0] INST_NOP   = 2'b00;
    localparam logic [1:0] INST_KLOAD = 2'b01;
    localparam logic [1:0] INST_EXEC  = 2'b11;

endpackage

// File: rtl/skew_delay.sv
// Zero-reset shift register of configurable depth; q is d delayed by depth cycles.
module skew_delay #(
    parameter int width = 6,
    parameter int depth = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    logic [width-1:0] sr [depth];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < depth; i++) sr[i] <= '0;
        end else begin
            sr[0] <= d;
            for (int unsigned i = 1; i < depth; i++) sr[i] <= sr[i-1];
        end
    end

    assign q = sr[depth-1];

endmodule

// File: rtl/west_edge_feeder.sv
// West-edge transmitter: kernel load, execute, drain, with per-row diagonal skew.
// Optional FEEDER_STATS_EN adds a per-run bubble counter output stall_cnt.
module west_edge_feeder
    import feeder_pkg::*;
#(
    parameter int bw     = 4,
    parameter int row    = 8,
    parameter int col    = 8,
    parameter int cnt_bw = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [cnt_bw-1:0]   num_act,
    input  logic                in_valid,
    input  logic [row*bw-1:0]   in_data,
    output logic                in_ready,
    output logic [row*bw-1:0]   out_w,
    output logic [row*2-1:0]    inst_w,
    output logic                busy,
    output logic                done
`ifdef FEEDER_STATS_EN
    ,
    output logic [15:0]         stall_cnt
`endif
);

    localparam int KW = (col > 1) ? $clog2(col) : 1;
    localparam int DW = $clog2(row + col);

    state_t             state;
    logic [KW-1:0]      kcnt;
    logic [cnt_bw-1:0]  acnt;
    logic [cnt_bw-1:0]  num_q;
    logic [DW-1:0]      dcnt;
    logic               accept;
    logic [row*bw-1:0]  base_data;
    logic [1:0]         base_inst;

    always_comb begin
        in_ready = (state == KLOAD) || (state == EXEC);
        busy     = (state == KLOAD) || (state == EXEC) || (state == DRAIN);
        accept   = in_valid && in_ready;
        base_data = '0;
        base_inst = INST_NOP;
        if (accept) begin
            base_data = in_data;
            base_inst = (state == KLOAD) ? INST_KLOAD : INST_EXEC;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            kcnt  <= '0;
            acnt  <= '0;
            num_q <= '0;
            dcnt  <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        num_q <= num_act;
                        kcnt  <= '0;
                        acnt  <= '0;
                        state <= KLOAD;
                    end
                end
                KLOAD: begin
                    if (in_valid) begin
                        if (kcnt == KW'(col - 1)) begin
                            kcnt  <= '0;
                            dcnt  <= '0;
                            state <= (num_q == '0) ? DRAIN : EXEC;
                        end else begin
                            kcnt <= kcnt + KW'(1);
                        end
                    end
                end
                EXEC: begin
                    if (in_valid) begin
                        if (acnt + cnt_bw'(1) == num_q) begin
                            acnt  <= '0;
                            dcnt  <= '0;
                            state <= DRAIN;
                        end else begin
                            acnt <= acnt + cnt_bw'(1);
                        end
                    end
                end
                DRAIN: begin
                    // row-1+col drain cycles: last one sees dcnt == row+col-2
                    if (dcnt == DW'(row + col - 2)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar r = 0; r < row; r++) begin : g_lane
        logic [bw+1:0] lane_q;

        skew_delay #(
            .width(bw + 2),
            .depth(r + 1)
        ) u_dly (
            .clk  (clk),
            .reset(reset),
            .d    ({base_inst, base_data[r*bw +: bw]}),
            .q    (lane_q)
        );

        assign out_w[r*bw +: bw] = lane_q[bw-1:0];
        assign inst_w[2*r +: 2]  = lane_q[bw+1:bw];
    end

`ifdef FEEDER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (state == IDLE && start) begin
            stall_cnt <= '0;
        end else if (in_ready && !in_valid && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_west_edge_feeder.sv
// Randomized bench for west_edge_feeder (row=4, col=4, bw=4) against a run-level reference model.
module tb_west_edge_feeder;

    localparam int BW   = 4;
    localparam int ROW  = 4;
    localparam int COL  = 4;
    localparam int CBW  = 8;
    localparam int DWID = ROW * BW;
    localparam int MAXC = 1024;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [CBW-1:0]   num_act;
    logic             in_valid;
    logic [DWID-1:0]  in_data;
    logic             in_ready;
    logic [DWID-1:0]  out_w;
    logic [ROW*2-1:0] inst_w;
    logic             busy;
    logic             done;
`ifdef FEEDER_STATS_EN
    logic [15:0]      stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    bit              vq   [MAXC];
    logic [DWID-1:0] dq   [MAXC];
    logic [DWID-1:0] bdat [MAXC];
    logic [1:0]      binst[MAXC];

    west_edge_feeder #(
        .bw(BW), .row(ROW), .col(COL), .cnt_bw(CBW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .num_act(num_act),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_w(out_w), .inst_w(inst_w), .busy(busy), .done(done)
`ifdef FEEDER_STATS_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Plan a run: valid pattern per cycle, and the un-skewed beat each cycle presents.
    // The first COL accepted beats are kernel beats, the next na are activations.
    task automatic plan(input int na, input int mode, output int last, output int stalls);
        int acc = 0;
        int c   = 1;
        stalls = 0;
        while (acc < COL + na) begin
            bit v;
            if (mode == 0)      v = 1'b1;
            else if (mode == 1) v = (c != 2);
            else                v = (c > 600) || ($urandom_range(0, 3) != 0);
            vq[c] = v;
            dq[c] = DWID'($urandom());
            if (v) begin
                bdat[c]  = dq[c];
                binst[c] = (acc < COL) ? 2'b01 : 2'b11;
                acc++;
            end else begin
                bdat[c]  = '0;
                binst[c] = 2'b00;
                stalls++;
            end
            c++;
        end
        last = c - 1;
    endtask

    task automatic do_run(input int na, input int mode, input int rst_at);
        int last, stalls, tend;
        plan(na, mode, last, stalls);
        tend = last + ROW + COL;
        if (rst_at >= 0 && rst_at + 4 < tend) tend = rst_at + 4;
        for (int t = 0; t <= tend; t++) begin
            logic [DWID-1:0]  e_w;
            logic [ROW*2-1:0] e_i;
            bit zero = (rst_at >= 0 && t > rst_at);
            e_w = '0;
            e_i = '0;
            if (!zero) begin
                for (int r = 0; r < ROW; r++) begin
                    int src = t - 1 - r;
                    if (src >= 1 && src <= last) begin
                        e_w[r*BW +: BW] = bdat[src][r*BW +: BW];
                        e_i[2*r +: 2]   = binst[src];
                    end
                end
            end
            @(negedge clk);
            chk("out_w",    64'(out_w),  64'(e_w));
            chk("inst_w",   64'(inst_w), 64'(e_i));
            chk("in_ready", 64'(in_ready), 64'(!zero && t >= 1 && t <= last));
            chk("busy",     64'(busy),     64'(!zero && t >= 1 && t <= last + ROW - 1 + COL));
            chk("done",     64'(done),     64'(!zero && t == last + ROW + COL));
`ifdef FEEDER_STATS_EN
            if (zero || t == 1) chk("stall_clr", 64'(stall_cnt), 64'(0));
            if (!zero && t == last + ROW + COL) chk("stall_cnt", 64'(stall_cnt), 64'(stalls));
`endif
            reset    = (t == rst_at);
            start    = (t == 0) ? 1'b1 : (rst_at >= 0 && t >= rst_at) ? 1'b0 : ($urandom_range(0, 5) == 0);
            num_act  = (t == 0) ? CBW'(na) : CBW'($urandom());
            in_valid = (t >= 1 && t <= last) ? vq[t] : 1'($urandom());
            in_data  = (t >= 1 && t <= last) ? dq[t] : DWID'($urandom());
        end
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        num_act  = '0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_w",    64'(out_w),    64'(0));
        chk("rst_inst_w",   64'(inst_w),   64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_busy",     64'(busy),     64'(0));
        chk("rst_done",     64'(done),     64'(0));
        reset = 1'b0;

        do_run(3, 0, -1);
        do_run(3, 1, -1);
        do_run(0, 0, -1);
        do_run(3, 0, 6);
        do_run(3, 0, -1);
        do_run(1, 2, -1);
        for (int k = 0; k < 6; k++) do_run($urandom_range(0, 20), 2, -1);
        do_run(255, 0, -1);
        do_run(5, 2, 9);
        do_run(2, 2, -1);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
